// File: rtl/dmem_responder.sv
// Local RV64 data-memory responder: one request in flight, fixed wait states.
// Define DMEM_MISALIGN_TRAP_EN to fault accesses not aligned to their size.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic        in_we,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wr_data,
    output logic        out_rsp_valid,
    input  logic        in_rsp_ready,
    output logic [63:0] out_rd_data,
    output logic        out_err
);

    localparam int WORDS = 1 << (ADDR_W - 3);
    localparam int IDX_W = ADDR_W - 3;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] wr_data;
    } req_t;

    state_t           state_q;
    state_t           state_d;
    req_t             req_q;
    logic [CNT_W-1:0] cnt_q;
    logic             live_q;
    logic [63:0]      rd_data_q;
    logic             err_q;
    logic             accept;
    logic             do_access;

    logic [63:0]      mem_q [WORDS];

    logic [IDX_W-1:0] idx;
    logic [2:0]       lane;
    logic [7:0]       be_base;
    logic [7:0]       be;
    logic [63:0]      wdata_sh;
    logic [63:0]      rword;
    logic [63:0]      rsh;
    logic [63:0]      ld_val;
    logic             range_err;
    logic             fn_err;
    logic             mis_err;
    logic             any_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (cnt_q == '0) state_d = RESP;
            RESP: if (in_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // live_q keeps the port closed until the first edge after reset release
    always_comb begin
        out_req_ready = live_q && (state_q == IDLE);
        out_rsp_valid = (state_q == RESP);
        accept        = in_req_valid && out_req_ready;
        do_access     = (state_q == BUSY) && (cnt_q == '0);
    end

    assign out_rd_data = rd_data_q;
    assign out_err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            cnt_q     <= '0;
            live_q    <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                req_q <= '{we: in_we, funct3: in_funct3,
                           addr: in_addr, wr_data: in_wr_data};
                cnt_q <= CNT_W'(WAIT_CYCLES);
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (do_access) begin
                err_q     <= any_err;
                rd_data_q <= (any_err || req_q.we) ? 64'd0 : ld_val;
            end
        end
    end

    // Size decode; low lane bits below the access size are dropped
    always_comb begin
        idx     = req_q.addr[ADDR_W-1:3];
        lane    = req_q.addr[2:0];
        be_base = 8'h00;
        unique case (req_q.funct3[1:0])
            2'b00: be_base = 8'h01;
            2'b01: begin
                be_base = 8'h03;
                lane[0] = 1'b0;
            end
            2'b10: begin
                be_base   = 8'h0F;
                lane[1:0] = 2'b00;
            end
            default: begin
                be_base = 8'hFF;
                lane    = 3'b000;
            end
        endcase
        be       = be_base << lane;
        wdata_sh = req_q.wr_data << {lane, 3'b000};
        rword    = mem_q[idx];
        rsh      = rword >> {lane, 3'b000};
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        unique case (req_q.funct3[1:0])
            2'b01:   mis_err = req_q.addr[0];
            2'b10:   mis_err = |req_q.addr[1:0];
            2'b11:   mis_err = |req_q.addr[2:0];
            default: mis_err = 1'b0;
        endcase
    end
`else
    assign mis_err = 1'b0;
`endif

    always_comb begin
        range_err = |req_q.addr[63:ADDR_W];
        fn_err    = req_q.we ? req_q.funct3[2] : (req_q.funct3 == 3'b111);
        any_err   = range_err | fn_err | mis_err;
    end

    always_comb begin
        ld_val = '0;
        unique case (1'b1)
            (req_q.funct3 == 3'b000): ld_val = {{56{rsh[7]}}, rsh[7:0]};
            (req_q.funct3 == 3'b001): ld_val = {{48{rsh[15]}}, rsh[15:0]};
            (req_q.funct3 == 3'b010): ld_val = {{32{rsh[31]}}, rsh[31:0]};
            (req_q.funct3 == 3'b011): ld_val = rsh;
            (req_q.funct3 == 3'b100): ld_val = {56'd0, rsh[7:0]};
            (req_q.funct3 == 3'b101): ld_val = {48'd0, rsh[15:0]};
            (req_q.funct3 == 3'b110): ld_val = {32'd0, rsh[31:0]};
            default:                  ld_val = '0;
        endcase
    end

    // Array is never reset; a write happens only on a clean store access
    always_ff @(posedge clk) begin
        if (do_access && req_q.we && !any_err) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem_q[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=12, WAIT_CYCLES=1).
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int ADDR_W = 12;
    localparam int WAIT_CYCLES = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_req_valid = 1'b0;
    logic        out_req_ready;
    logic        in_we = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [63:0] in_addr = 64'd0;
    logic [63:0] in_wr_data = 64'd0;
    logic        out_rsp_valid;
    logic        in_rsp_ready = 1'b0;
    logic [63:0] out_rd_data;
    logic        out_err;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] r_data;
    logic        r_err;
    int          r_lat;
    time         t_acc;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_req_valid(in_req_valid),
        .out_req_ready(out_req_ready),
        .in_we(in_we),
        .in_funct3(in_funct3),
        .in_addr(in_addr),
        .in_wr_data(in_wr_data),
        .out_rsp_valid(out_rsp_valid),
        .in_rsp_ready(in_rsp_ready),
        .out_rd_data(out_rd_data),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd);
        int n = 0;
        @(negedge clk);
        while (!out_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_req_valid = 1'b1;
        in_we = we;
        in_funct3 = f3;
        in_addr = addr;
        in_wr_data = wd;
        @(posedge clk);
        t_acc = $time;
        #1 in_req_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        r_lat = 0;
        do begin
            @(posedge clk);
            r_lat++;
            #1;
        end while (!out_rsp_valid && r_lat < 20);
        r_data = out_rd_data;
        r_err = out_err;
        in_rsp_ready = 1'b1;
        @(posedge clk);
        #1 in_rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd);
        issue(we, f3, addr, wd);
        finish_rsp();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        n_chk++;
        if (out_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready: got %b want 0", out_req_ready);
        end
        n_chk++;
        if (out_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid: got %b want 0", out_rsp_valid);
        end
        n_chk++;
        if (out_rd_data !== 64'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_data: got %h/%b want 0/0", out_rd_data, out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (out_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b want 1", out_req_ready);
        end
    endtask

    task automatic test_load_store();
        logic [2:0]  f3s [7] = '{3'b011, 3'b000, 3'b100, 3'b010,
                                 3'b110, 3'b001, 3'b101};
        logic [63:0] ads [7] = '{64'h10, 64'h10, 64'h10, 64'h14,
                                 64'h14, 64'h10, 64'h10};
        logic [63:0] exp [7] = '{64'h8000_0000_FFFF_FF80,
                                 64'hFFFF_FFFF_FFFF_FF80,
                                 64'h0000_0000_0000_0080,
                                 64'hFFFF_FFFF_8000_0000,
                                 64'h0000_0000_8000_0000,
                                 64'hFFFF_FFFF_FFFF_FF80,
                                 64'h0000_0000_0000_FF80};
        xact(1'b1, 3'b011, 64'h10, 64'h8000_0000_FFFF_FF80);
        n_chk++;
        if (r_lat !== 2 || r_err !== 1'b0 || r_data !== 64'd0) begin
            n_fail++;
            $display("FAIL sd_rsp: lat %0d err %b data %h want 2 0 0",
                     r_lat, r_err, r_data);
        end
        for (int i = 0; i < 7; i++) begin
            xact(1'b0, f3s[i], ads[i], 64'd0);
            n_chk++;
            if (r_data !== exp[i] || r_err !== 1'b0 || r_lat !== 2) begin
                n_fail++;
                $display("FAIL load_%0d: data %h err %b lat %0d want %h 0 2",
                         i, r_data, r_err, r_lat, exp[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        xact(1'b1, 3'b000, 64'h11, 64'hDEAD_BEEF_CAFE_12AB);
        n_chk++;
        if (r_err !== 1'b0 || r_data !== 64'd0) begin
            n_fail++;
            $display("FAIL sb_rsp: err %b data %h want 0 0", r_err, r_data);
        end
        xact(1'b0, 3'b011, 64'h10, 64'd0);
        n_chk++;
        if (r_data !== 64'h8000_0000_FFFF_AB80) begin
            n_fail++;
            $display("FAIL sb_merge: got %h want 8000_0000_ffff_ab80", r_data);
        end
        xact(1'b1, 3'b011, 64'h18, 64'd0);
        xact(1'b1, 3'b001, 64'h1A, 64'h7777_6666_5555_BEEF);
        xact(1'b1, 3'b010, 64'h1C, 64'h9999_8888_1122_3344);
        xact(1'b0, 3'b011, 64'h18, 64'd0);
        n_chk++;
        if (r_data !== 64'h1122_3344_BEEF_0000) begin
            n_fail++;
            $display("FAIL sh_sw_merge: got %h want 1122_3344_beef_0000", r_data);
        end
    endtask

    task automatic test_errors();
        logic        wes [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0]  f3s [6] = '{3'b011, 3'b011, 3'b111,
                                 3'b100, 3'b111, 3'b011};
        logic [63:0] ads [6] = '{64'h1000, 64'h8000_0000_0000_0010, 64'h10,
                                 64'h10, 64'h10, 64'h1010};
        for (int i = 0; i < 6; i++) begin
            xact(wes[i], f3s[i], ads[i], 64'hFFFF_FFFF_FFFF_FFFF);
            n_chk++;
            if (r_err !== 1'b1 || r_data !== 64'd0 || r_lat !== 2) begin
                n_fail++;
                $display("FAIL err_%0d: err %b data %h lat %0d want 1 0 2",
                         i, r_err, r_data, r_lat);
            end
        end
        xact(1'b0, 3'b011, 64'h10, 64'd0);
        n_chk++;
        if (r_data !== 64'h8000_0000_FFFF_AB80 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_nowrite: got %h/%b want 8000_0000_ffff_ab80/0",
                     r_data, r_err);
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b101, 3'b100};
        logic [63:0] ads [4] = '{64'h12, 64'h13, 64'h11, 64'h13};
        logic [63:0] raw [4] = '{64'hFFFF_FFFF_FFFF_AB80,
                                 64'h8000_0000_FFFF_AB80,
                                 64'h0000_0000_0000_AB80,
                                 64'h0000_0000_0000_00FF};
        logic        mis [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] e_d;
        logic        e_e;
        for (int i = 0; i < 4; i++) begin
            e_e = TRAP && mis[i];
            e_d = e_e ? 64'd0 : raw[i];
            xact(1'b0, f3s[i], ads[i], 64'd0);
            n_chk++;
            if (r_data !== e_d || r_err !== e_e) begin
                n_fail++;
                $display("FAIL misalign_%0d: got %h/%b want %h/%b",
                         i, r_data, r_err, e_d, e_e);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int bad = 0;
        issue(1'b0, 3'b011, 64'h10, 64'd0);
        in_req_valid = 1'b1;
        in_we = 1'b1;
        in_funct3 = 3'b000;
        in_addr = 64'h18;
        in_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        while (!out_rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (5) begin
            if (out_rsp_valid !== 1'b1 || out_req_ready !== 1'b0 ||
                out_rd_data !== 64'h8000_0000_FFFF_AB80 || out_err !== 1'b0)
                bad++;
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
        end
        in_req_valid = 1'b0;
        in_we = 1'b0;
        in_rsp_ready = 1'b1;
        @(posedge clk);
        #1 in_rsp_ready = 1'b0;
        n_chk++;
        if (out_rsp_valid !== 1'b0 || out_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: valid %b ready %b want 0 1",
                     out_rsp_valid, out_req_ready);
        end
        xact(1'b0, 3'b011, 64'h18, 64'd0);
        n_chk++;
        if (r_data !== 64'h1122_3344_BEEF_0000) begin
            n_fail++;
            $display("FAIL no_resample: got %h want 1122_3344_beef_0000", r_data);
        end
    endtask

    task automatic test_back_to_back();
        time t1;
        xact(1'b0, 3'b011, 64'h10, 64'd0);
        t1 = t_acc;
        n_chk++;
        if (r_data !== 64'h8000_0000_FFFF_AB80) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want 8000_0000_ffff_ab80", r_data);
        end
        xact(1'b0, 3'b100, 64'h11, 64'd0);
        n_chk++;
        if (r_data !== 64'h0000_0000_0000_00AB) begin
            n_fail++;
            $display("FAIL b2b_second: got %h want ab", r_data);
        end
        n_chk++;
        if ((t_acc - t1) !== 64'd40) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0t want 40", t_acc - t1);
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        xact(1'b1, 3'b011, 64'h20, 64'h5555);
        xact(1'b0, 3'b011, 64'h20, 64'd0);
        n_chk++;
        if (r_data !== 64'h5555) begin
            n_fail++;
            $display("FAIL abort_pre: got %h want 5555", r_data);
        end
        issue(1'b1, 3'b011, 64'h20, 64'hAAAA);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_rsp_valid !== 1'b0 || out_req_ready !== 1'b0 ||
            out_rd_data !== 64'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: v %b r %b d %h e %b want 0 0 0 0",
                     out_rsp_valid, out_req_ready, out_rd_data, out_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_rsp_valid) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_rsp: got %0d valid cycles want 0", seen);
        end
        xact(1'b0, 3'b011, 64'h20, 64'd0);
        n_chk++;
        if (r_data !== 64'h5555 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_write: got %h/%b want 5555/0", r_data, r_err);
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_byte_store();
        test_errors();
        test_misalign();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want test end");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving the byte-address width of the local array (2^ADDR_W bytes, organised as 2^(ADDR_W-3) 64-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving the extra busy cycles inserted before each access (0 allowed).
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst_N  input  1  reset, asynchronous, active-low.
REQ-005 in_req_valid  input  1  the datapath presents a request.
REQ-006 out_req_ready  output  1  the responder can accept a request.
REQ-007 in_we  input  1  1 = store, 0 = load.
REQ-008 in_funct3  input  3  RV64 load/store funct3 (size and sign).
REQ-009 in_addr  input  64  byte address.
REQ-010 in_wr_data  input  64  store data, right-aligned.
REQ-011 out_rsp_valid  output  1  response present.
REQ-012 in_rsp_ready  input  1  the datapath consumes the response.
REQ-013 out_rd_data  output  64  load result, extended to 64 bits.
REQ-014 out_err  output  1  request faulted; qualified by out_rsp_valid.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and RESP.
REQ-016 out_req_ready SHALL be 1 only in IDLE; in_req_valid & out_req_ready SHALL latch we, funct3, addr and wr_data, load the wait counter with WAIT_CYCLES, and move the FSM to BUSY.
REQ-017 In BUSY, a counter of 0 SHALL perform the access on that edge and move the FSM to RESP; otherwise the counter SHALL decrement.
REQ-018 out_rsp_valid SHALL rise WAIT_CYCLES+1 cycles after the accept edge and stay high with stable out_rd_data and out_err until in_rsp_ready is sampled high; the FSM SHALL then return to IDLE.
REQ-019 A new request SHALL NOT be accepted in the cycle where the response handshakes, which gives a minimum of WAIT_CYCLES+3 cycles per transaction.
REQ-020 Byte order SHALL be little-endian; word index = addr[ADDR_W-1:3]; byte lane = addr[2:0].
REQ-021 Loads: funct3 000/001/010/011 SHALL return LB/LH/LW/LD sign-extended, and 100/101/110 SHALL return LBU/LHU/LWU zero-extended.
REQ-022 Stores: funct3 000/001/010/011 SHALL write 1/2/4/8 bytes from wr_data[7:0]/[15:0]/[31:0]/[63:0] using byte enables; other bytes in the word SHALL be unchanged.
REQ-023 Any of the following SHALL set out_err=1, perform no write, and give out_rd_data=0:
  - load funct3 111;
  - store funct3[2]=1;
  - addr[63:ADDR_W] nonzero.
REQ-024 Stores and errored requests SHALL return out_rd_data=0; every request SHALL produce exactly one response.
REQ-025 in_req_valid SHALL be ignored outside IDLE, and request inputs SHALL NOT be re-sampled after accept.

Reset
REQ-026 Rst_N low SHALL asynchronously force the following, irrespective of Clk:
  - FSM = IDLE, counter = 0;
  - out_req_ready = 0 while Rst_N is low, then 1 from the first cycle after release;
  - out_rsp_valid = 0, out_rd_data = 0, out_err = 0.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 A reset in BUSY before the access edge SHALL abort the request with no write and no response.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN, when defined, SHALL flag any address not aligned to the access size (half: addr[0]; word: addr[1:0]; double: addr[2:0] nonzero) as an error per REQ-023.
REQ-030 When DMEM_MISALIGN_TRAP_EN is undefined, the low address bits below the access size SHALL be ignored (address aligned down), with no error.

Verification
REQ-031 Reset, then SD addr 0x10 data 0x8000_0000_FFFF_FF80, then LD 0x10 -> rsp after 2 cycles (WAIT_CYCLES=1), rd_data 0x8000_0000_FFFF_FF80, err 0.
REQ-032 Following REQ-031, LB 0x10 -> 0xFFFF_FFFF_FFFF_FF80; LBU 0x10 -> 0x80; LW 0x14 -> 0xFFFF_FFFF_8000_0000; LWU 0x14 -> 0x8000_0000.
REQ-033 SB 0x11 data 0xAB over REQ-031 contents, then LD 0x10 -> 0x8000_0000_FFFF_AB80.
REQ-034 LD 0x1000 (ADDR_W=12) -> err 1, rd_data 0; store funct3 100 -> err 1 and array unchanged.
REQ-035 LW 0x12:
  - with DMEM_MISALIGN_TRAP_EN -> err 1;
  - without it -> rd_data of word 0x10, err 0.
REQ-036 Hold in_rsp_ready=0 for 5 cycles -> rsp_valid and rd_data stable and req_ready 0 throughout; assert Rst_N low in BUSY during a store -> no write, outputs zero.
